// File: rtl/compare16_pkg.sv
// Shared definitions for the half-precision compare unit and its result path:
// compare codes, result-queue FSM encoding, queue record and a tally helper.
package compare16_pkg;

  localparam logic [1:0] CMP_EQ  = 2'b00;
  localparam logic [1:0] CMP_GT  = 2'b01;
  localparam logic [1:0] CMP_LT  = 2'b10;
  localparam logic [1:0] CMP_BAD = 2'b11;

  localparam int REC_TAG_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_CODE = 2'd1,
    ST_CAPTURE   = 2'd2
  } cmp_state_e;

  typedef struct packed {
    logic [REC_TAG_W-1:0] tag;
    logic [1:0]           code;
    logic                 bad;
  } cmp_rec_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/compare16_result_queue_if.sv
// Result-queue bus: compare-unit stb/ack channel, consumer stb/ack channel and tallies.
// master = environment (compare unit + consumer), slave = the result queue.
interface compare16_result_queue_if #(parameter int TAG_W = 8);
  logic             cmp_z_stb;
  logic             cmp_z_ack;
  logic [1:0]       cmp_code;
  logic             res_stb;
  logic             res_ack;
  logic [1:0]       res_code;
  logic [TAG_W-1:0] res_tag;
  logic             res_bad;
  logic             clr_counts;
  logic [15:0]      eq_count;
  logic [15:0]      gt_count;
  logic [15:0]      lt_count;

  modport master (
    output cmp_z_stb, cmp_code, res_ack, clr_counts,
    input  cmp_z_ack, res_stb, res_code, res_tag, res_bad,
           eq_count, gt_count, lt_count
  );

  modport slave (
    input  cmp_z_stb, cmp_code, res_ack, clr_counts,
    output cmp_z_ack, res_stb, res_code, res_tag, res_bad,
           eq_count, gt_count, lt_count
  );
endinterface

// File: rtl/cmp_result_fifo.sv
// Synchronous show-ahead FIFO for FPU result records; DEPTH must be a power of two.
// Pushes while full (without a simultaneous pop) and pops while empty are ignored.
module cmp_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 11,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok_s, pop_ok_s;

  assign empty_o   = (count_q == {(AW+1){1'b0}});
  assign full_o    = (count_q == CNT_FULL);
  assign count_o   = count_q;
  assign pop_ok_s  = pop_i && !empty_o;
  assign push_ok_s = push_i && (!full_o || pop_ok_s);
  assign head_o    = empty_o ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

  // pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = push_ok_s ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop_ok_s  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage array; the head is masked while empty so it needs no reset
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/compare16_result_queue.sv
// Result queue behind the 16-bit compare unit: captures each compare code one
// cycle after the stb/ack handshake, tags it, queues it and keeps saturating tallies.
module compare16_result_queue
  import compare16_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 8
) (
  input logic                      clk,
  input logic                      rst,
  compare16_result_queue_if.slave  bus
);

  localparam int               CNT_W    = $clog2(DEPTH) + 1;
  localparam int               REC_W    = TAG_W + 3;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);

  cmp_state_e       state_q, state_d;
  logic             ack_q, ack_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [15:0]      eq_cnt_q, eq_cnt_d, eq_base_s;
  logic [15:0]      gt_cnt_q, gt_cnt_d, gt_base_s;
  logic [15:0]      lt_cnt_q, lt_cnt_d, lt_base_s;
  logic             push_s;
  logic             handshake_s;
  logic [REC_W-1:0] push_rec_s, head_rec_s;
  logic             fifo_empty_s, fifo_full_unused_s;
  logic [CNT_W-1:0] fifo_count_s;

  assign handshake_s = bus.cmp_z_stb && ack_q;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state: WAIT_CODE exists because the code register updates one edge after the handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (handshake_s) state_d = ST_WAIT_CODE;
        else             state_d = ST_IDLE;
      end
      ST_WAIT_CODE: state_d = ST_CAPTURE;
      ST_CAPTURE:   state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: ack request while space remains, push in CAPTURE
  always_comb begin
    ack_d  = 1'b0;
    push_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (handshake_s) ack_d = 1'b0;
        else             ack_d = bus.cmp_z_stb && (fifo_count_s < CNT_FULL);
      end
      ST_CAPTURE: push_s = 1'b1;
      default:    ack_d  = 1'b0;
    endcase
  end

  // tag and tally next-state; a clear coinciding with a capture still counts that capture
  always_comb begin
    tag_d     = push_s ? tag_q + TAG_ONE : tag_q;
    eq_base_s = bus.clr_counts ? 16'h0000 : eq_cnt_q;
    gt_base_s = bus.clr_counts ? 16'h0000 : gt_cnt_q;
    lt_base_s = bus.clr_counts ? 16'h0000 : lt_cnt_q;
    eq_cnt_d  = eq_base_s;
    gt_cnt_d  = gt_base_s;
    lt_cnt_d  = lt_base_s;
    if (push_s) begin
      case (bus.cmp_code)
        CMP_EQ:  eq_cnt_d = sat_inc16(eq_base_s);
        CMP_GT:  gt_cnt_d = sat_inc16(gt_base_s);
        CMP_LT:  lt_cnt_d = sat_inc16(lt_base_s);
        default: eq_cnt_d = eq_base_s;
      endcase
    end else begin
      eq_cnt_d = eq_base_s;
    end
  end

  // ack, tag counter and tally registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q    <= 1'b0;
      tag_q    <= {TAG_W{1'b0}};
      eq_cnt_q <= 16'h0000;
      gt_cnt_q <= 16'h0000;
      lt_cnt_q <= 16'h0000;
    end else begin
      ack_q    <= ack_d;
      tag_q    <= tag_d;
      eq_cnt_q <= eq_cnt_d;
      gt_cnt_q <= gt_cnt_d;
      lt_cnt_q <= lt_cnt_d;
    end
  end

  assign push_rec_s = {tag_q, bus.cmp_code, (bus.cmp_code == CMP_BAD)};

  cmp_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_s),
    .push_data_i (push_rec_s),
    .pop_i       (bus.res_ack),
    .head_o      (head_rec_s),
    .full_o      (fifo_full_unused_s),
    .empty_o     (fifo_empty_s),
    .count_o     (fifo_count_s)
  );

  assign bus.cmp_z_ack = ack_q;
  assign bus.res_stb   = !fifo_empty_s;
  assign bus.res_tag   = head_rec_s[REC_W-1:3];
  assign bus.res_code  = head_rec_s[2:1];
  assign bus.res_bad   = head_rec_s[0];
  assign bus.eq_count  = eq_cnt_q;
  assign bus.gt_count  = gt_cnt_q;
  assign bus.lt_count  = lt_cnt_q;

endmodule

// File: tb/tb_compare16_result_queue.sv
// Scoreboard bench for compare16_result_queue: directed results are queued as
// expected records at handshake time and a negedge monitor checks every pop.
module tb_compare16_result_queue;
  import compare16_pkg::*;

  logic clk = 1'b0;
  logic rst;

  compare16_result_queue_if #(.TAG_W(8)) bus ();

  compare16_result_queue #(.DEPTH(4), .TAG_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fails  = 0;
  cmp_rec_t   exp_q[$];
  logic [7:0] tb_tag;
  cmp_rec_t   mon_got, mon_want;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_tallies(input string name, input logic [15:0] eq,
                               input logic [15:0] gt, input logic [15:0] lt);
    check({name, "_eq"}, 32'(bus.eq_count), 32'(eq));
    check({name, "_gt"}, 32'(bus.gt_count), 32'(gt));
    check({name, "_lt"}, 32'(bus.lt_count), 32'(lt));
  endtask

  // monitor: every pop the DUT will take at the next edge is checked against the scoreboard
  always begin
    @(negedge clk);
    #1;
    if (!rst && bus.res_stb && bus.res_ack) begin
      mon_got.tag  = bus.res_tag;
      mon_got.code = bus.res_code;
      mon_got.bad  = bus.res_bad;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL unexpected_pop: got record 0x%0h, expected none", mon_got);
      end else begin
        mon_want = exp_q.pop_front();
        check("pop_record", 32'(mon_got), 32'(mon_want));
      end
    end
  end

  // one result through the compare-unit handshake; code changes one edge after the handshake
  task automatic send(input logic [1:0] code, input bit pop_at_cap, input bit clr_at_cap,
                      input int budget, output logic stb_e1, output logic stb_e2, output bit ok);
    int       waited;
    cmp_rec_t r;
    waited = 0;
    ok     = 1'b0;
    stb_e1 = 1'b0;
    stb_e2 = 1'b0;
    bus.cmp_code  = ~code;
    bus.cmp_z_stb = 1'b1;
    @(negedge clk);
    while (!bus.cmp_z_ack && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.cmp_z_ack) begin
      bus.cmp_z_stb = 1'b0;
      check("ack_timeout", 32'(bus.cmp_z_ack), 32'd1);
      return;
    end
    r.tag  = tb_tag;
    r.code = code;
    r.bad  = (code == 2'b11);
    exp_q.push_back(r);
    tb_tag = tb_tag + 8'd1;
    @(negedge clk);
    bus.cmp_z_stb = 1'b0;
    check("ack_after_handshake", 32'(bus.cmp_z_ack), 32'd0);
    @(negedge clk);
    stb_e1       = bus.res_stb;
    bus.cmp_code = code;
    if (pop_at_cap) bus.res_ack = 1'b1;
    if (clr_at_cap) bus.clr_counts = 1'b1;
    @(negedge clk);
    stb_e2 = bus.res_stb;
    if (pop_at_cap) bus.res_ack = 1'b0;
    bus.clr_counts = 1'b0;
    ok = 1'b1;
  endtask

  task automatic drain();
    bus.res_ack = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_left", 32'(exp_q.size()), 32'd0);
    bus.res_ack = 1'b0;
    check("drain_empty", 32'(bus.res_stb), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    bus.cmp_z_stb = 1'b0;
    bus.res_ack   = 1'b0;
    bus.clr_counts = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    tb_tag = 8'd0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       e1, e2, saw_ack;
    bit         ok;
    logic [1:0] t3_codes [5];
    t3_codes = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};

    bus.cmp_z_stb  = 1'b0;
    bus.cmp_code   = 2'b00;
    bus.res_ack    = 1'b0;
    bus.clr_counts = 1'b0;
    rst    = 1'b1;
    tb_tag = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("reset_outputs", 32'({bus.cmp_z_ack, bus.res_stb, bus.res_code, bus.res_tag, bus.res_bad}), 32'd0);
    end
    check_tallies("reset", 16'd0, 16'd0, 16'd0);

    // 2: single code 01
    send(2'b01, 1'b0, 1'b0, 20, e1, e2, ok);
    check("t2_stb_after_e1", 32'(e1), 32'd0);
    check("t2_stb_after_e2", 32'(e2), 32'd1);
    check("t2_head_tag", 32'(bus.res_tag), 32'h00);
    check("t2_head_code", 32'(bus.res_code), 32'd1);
    check_tallies("t2", 16'd0, 16'd1, 16'd0);
    drain();
    do_reset();

    // 3: backpressure with DEPTH=4
    for (int i = 0; i < 4; i++) send(t3_codes[i], 1'b0, 1'b0, 20, e1, e2, ok);
    fork
      send(t3_codes[4], 1'b0, 1'b0, 60, e1, e2, ok);
      begin
        saw_ack = 1'b0;
        repeat (10) begin
          @(negedge clk);
          if (bus.cmp_z_ack) saw_ack = 1'b1;
        end
        check("t3_no_ack_when_full", 32'(saw_ack), 32'd0);
        check("t3_head_tag_full", 32'(bus.res_tag), 32'h00);
        bus.res_ack = 1'b1;
        @(negedge clk);
        bus.res_ack = 1'b0;
      end
    join
    check("t3_fifth_accepted", 32'(ok), 32'd1);
    drain();
    check_tallies("t3", 16'd2, 16'd1, 16'd1);

    // 4: pop and capture on the same edge at count=1
    send(2'b10, 1'b0, 1'b0, 20, e1, e2, ok);
    check("t4_preload_tag", 32'(bus.res_tag), 32'h05);
    send(2'b01, 1'b1, 1'b0, 20, e1, e2, ok);
    check("t4_stb", 32'(bus.res_stb), 32'd1);
    check("t4_new_head_tag", 32'(bus.res_tag), 32'h06);
    @(negedge clk);
    check("t4_head_code_hold", 32'(bus.res_code), 32'd1);
    drain();
    check_tallies("t4", 16'd2, 16'd2, 16'd2);

    // 5: tag wrap, saturation, clear with capture
    do_reset();
    bus.res_ack = 1'b1;
    repeat (255) send(2'b00, 1'b0, 1'b0, 20, e1, e2, ok);
    check_tallies("t5_bulk", 16'd255, 16'd0, 16'd0);
    send(2'b01, 1'b0, 1'b0, 20, e1, e2, ok);
    send(2'b10, 1'b0, 1'b0, 20, e1, e2, ok);
    check_tallies("t5_wrap", 16'd255, 16'd1, 16'd1);
    @(negedge clk);
    force dut.eq_cnt_q = 16'hFFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.eq_cnt_q;
    send(2'b00, 1'b0, 1'b0, 20, e1, e2, ok);
    check("t5_eq_reach_sat", 32'(bus.eq_count), 32'h0000FFFF);
    send(2'b00, 1'b0, 1'b0, 20, e1, e2, ok);
    check("t5_eq_hold_sat", 32'(bus.eq_count), 32'h0000FFFF);
    send(2'b10, 1'b0, 1'b1, 20, e1, e2, ok);
    check_tallies("t5_clr_cap", 16'd0, 16'd0, 16'd1);

    // 6: illegal code, then reset while WAIT_CODE
    send(2'b11, 1'b0, 1'b0, 20, e1, e2, ok);
    check_tallies("t6_bad", 16'd0, 16'd0, 16'd1);
    drain();
    bus.cmp_code  = 2'b01;
    bus.cmp_z_stb = 1'b1;
    for (int i = 0; i < 20 && !bus.cmp_z_ack; i++) @(negedge clk);
    check("t6_ack_seen", 32'(bus.cmp_z_ack), 32'd1);
    @(negedge clk);
    bus.cmp_z_stb = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_stb", 32'(bus.res_stb), 32'd0);
    check("t6_rst_ack", 32'(bus.cmp_z_ack), 32'd0);
    check_tallies("t6_rst", 16'd0, 16'd0, 16'd0);
    rst = 1'b0;
    exp_q.delete();
    tb_tag = 8'd0;
    repeat (4) @(negedge clk);
    check("t6_no_push", 32'(bus.res_stb), 32'd0);
    send(2'b10, 1'b0, 1'b0, 20, e1, e2, ok);
    check("t6_tag_restart", 32'(bus.res_tag), 32'h00);
    check("t6_code_after", 32'(bus.res_code), 32'd2);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
